// File: rtl/iir_input_fifo.sv
// Input stage for iir_section2: buffers valid/ready samples, then streams exactly one per clock
// once PREFILL samples are stored; feeds zeros and re-primes on underflow.
module iir_input_fifo #(
    parameter int W       = 11,
    parameter int DEPTH   = 8,
    parameter int PREFILL = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [W-1:0]          din,
    input  logic                         din_valid,
    output logic                         din_ready,
    output logic signed [W-1:0]          x,
    output logic                         running,
    output logic                         underflow,
    output logic [$clog2(DEPTH+1)-1:0]   level
);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {PRIME, RUN} state_t;

    state_t              state_reg, state_next;
    logic [AW-1:0]       wptr_reg, rptr_reg;
    logic [LW-1:0]       level_reg, level_next;
    logic signed [W-1:0] x_reg;
    logic                underflow_reg, underflow_next;
    logic                wr, rd;

    logic signed [W-1:0] mem [DEPTH];

    // A full FIFO refuses writes even when a pop happens on the same edge.
    assign din_ready = (level_reg != LW'(DEPTH));
    assign wr        = din_valid && din_ready;
    assign rd        = (state_reg == RUN) && (level_reg != '0);

    always_comb begin
        state_next     = state_reg;
        underflow_next = underflow_reg;
        case (state_reg)
            PRIME: begin
                if (level_reg >= LW'(PREFILL))
                    state_next = RUN;
            end
            RUN: begin
                if (level_reg == '0) begin
                    underflow_next = 1'b1;
                    state_next     = PRIME;
                end
            end
            default: state_next = PRIME;
        endcase
    end

    always_comb begin
        level_next = level_reg;
        case ({wr, rd})
            2'b10:   level_next = level_reg + 1'b1;
            2'b01:   level_next = level_reg - 1'b1;
            default: level_next = level_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= PRIME;
            level_reg     <= '0;
            wptr_reg      <= '0;
            rptr_reg      <= '0;
            underflow_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            level_reg     <= level_next;
            underflow_reg <= underflow_next;
            if (wr)
                wptr_reg <= wptr_reg + 1'b1;
            if (rd)
                rptr_reg <= rptr_reg + 1'b1;
        end
    end

    // Storage words carry no reset so the array maps onto block/distributed RAM.
    always_ff @(posedge clk) begin
        if (wr)
            mem[wptr_reg] <= din;
    end

    // Registered read doubles as the x output register; zero whenever nothing is popped.
    always_ff @(posedge clk) begin
        if (rst)
            x_reg <= '0;
        else if (rd)
            x_reg <= mem[rptr_reg];
        else
            x_reg <= '0;
    end

    assign x         = x_reg;
    assign running   = (state_reg == RUN);
    assign underflow = underflow_reg;
    assign level     = level_reg;
endmodule
